// File: rtl/dma_arb_pkg.sv
// Shared types and default widths for the DMA channel arbiter.
// Optional watchdog in the arbiter is enabled with DMA_ARB_TIMEOUT_EN.
package dma_arb_pkg;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_LEN_W       = 5;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int TO_CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    COMPLETE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dma_channel_arbiter_rr_priority_enc.sv
// Round-robin priority encoder: picks the first set request at or after ptr,
// wrapping around. Rotate the request vector so ptr lands on bit 0, find the
// lowest set bit, then add ptr back (mod NUM_CH) to recover the channel index.
module rr_priority_enc
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic              valid,
  output logic [PTR_W-1:0]  idx
);

  localparam logic [PTR_W:0] NUM_CH_W = (PTR_W+1)'(NUM_CH);

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rotated;
  logic [PTR_W:0]      first;
  logic [PTR_W:0]      sum;
  logic [PTR_W:0]      wrapped;

  // Rotate, find-first-set, and unrotate back to an absolute channel index
  always_comb begin
    doubled = {req, req};
    rotated = doubled[ptr +: NUM_CH];
    first   = {(PTR_W+1){1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      first = rotated[k] ? k[PTR_W:0] : first;
    end
    sum     = first + {1'b0, ptr};
    wrapped = sum - NUM_CH_W;
    if (sum >= NUM_CH_W) begin
      idx = wrapped[PTR_W-1:0];
    end else begin
      idx = sum[PTR_W-1:0];
    end
    valid = |req;
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares one DMA engine between NUM_CH channels. Grants round-robin, latches the
// winner's descriptor onto the engine port, fires a one-cycle trigger, and returns
// a per-channel done pulse on the engine's done rising edge. Zero-length
// descriptors complete without touching the engine.
// Define DMA_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that pulses ch_err.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int LEN_W       = DEF_LEN_W,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int PTR_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic                     busy,
  output logic [PTR_W-1:0]         grant_id,
  output logic                     dma_trigger,
  output logic [LEN_W-1:0]         dma_length,
  output logic [ADDR_W-1:0]        dma_src,
  output logic [ADDR_W-1:0]        dma_dst,
  input  logic                     dma_done
);

  localparam logic [PTR_W-1:0]    LAST_CH  = PTR_W'(NUM_CH - 1);
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic              done_q;
  logic              done_edge;
  logic              enc_valid;
  logic [PTR_W-1:0]  enc_idx;
  logic [PTR_W-1:0]  next_ptr;

  logic [LEN_W-1:0]  len_arr [NUM_CH];
  logic [ADDR_W-1:0] src_arr [NUM_CH];
  logic [ADDR_W-1:0] dst_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign len_arr[i] = ch_len[i*LEN_W +: LEN_W];
    assign src_arr[i] = ch_src[i*ADDR_W +: ADDR_W];
    assign dst_arr[i] = ch_dst[i*ADDR_W +: ADDR_W];
  end

  // A done level that was already high before launch produces no edge here
  assign done_edge = dma_done & ~done_q;
  assign next_ptr  = (grant_id == LAST_CH) ? {PTR_W{1'b0}} : grant_id + PTR_W'(1);

  rr_priority_enc #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_enc (
    .req   (ch_req),
    .ptr   (rr_ptr),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

`ifdef DMA_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LIMIT;
  assign ch_err         = {NUM_CH{1'b0}};
`endif

  // Arbitration FSM with all outputs registered; pulses default low each cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= {PTR_W{1'b0}};
      done_q      <= 1'b0;
      ch_ack      <= {NUM_CH{1'b0}};
      ch_done     <= {NUM_CH{1'b0}};
      busy        <= 1'b0;
      grant_id    <= {PTR_W{1'b0}};
      dma_trigger <= 1'b0;
      dma_length  <= {LEN_W{1'b0}};
      dma_src     <= {ADDR_W{1'b0}};
      dma_dst     <= {ADDR_W{1'b0}};
`ifdef DMA_ARB_TIMEOUT_EN
      ch_err      <= {NUM_CH{1'b0}};
      to_cnt      <= {TO_CNT_W{1'b0}};
`endif
    end else begin
      done_q      <= dma_done;
      ch_ack      <= {NUM_CH{1'b0}};
      ch_done     <= {NUM_CH{1'b0}};
      dma_trigger <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
      ch_err      <= {NUM_CH{1'b0}};
`endif
      case (state)
        IDLE: begin
          if (enc_valid) begin
            grant_id         <= enc_idx;
            ch_ack[enc_idx]  <= 1'b1;
            busy             <= 1'b1;
            dma_length       <= len_arr[enc_idx];
            dma_src          <= src_arr[enc_idx];
            dma_dst          <= dst_arr[enc_idx];
            state            <= (len_arr[enc_idx] != {LEN_W{1'b0}}) ? LAUNCH : COMPLETE;
          end
        end
        LAUNCH: begin
          dma_trigger <= 1'b1;
`ifdef DMA_ARB_TIMEOUT_EN
          to_cnt      <= {TO_CNT_W{1'b0}};
`endif
          state       <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_edge) begin
            state <= COMPLETE;
`ifdef DMA_ARB_TIMEOUT_EN
          end else if (to_cnt == TO_LIMIT) begin
            ch_err[grant_id] <= 1'b1;
            busy             <= 1'b0;
            rr_ptr           <= next_ptr;
            state            <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_CNT_W'(1);
`endif
          end
        end
        COMPLETE: begin
          ch_done[grant_id] <= 1'b1;
          busy              <= 1'b0;
          rr_ptr            <= next_ptr;
          state             <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
